sdram_arbit: RTL and testbench
==============================

Name: sdram_arbit

Overview:
- Arbitration and command-mux block between the SDRAM controller sub-modules and the SDRAM device pins.
- Sub-modules served: sdram_init, auto-refresh, sdram_write and sdram_read.
- Grants one requester at a time using a req/en/end handshake and routes the granted requester's cmd/ba/addr onto the pins.
- Owns the bidirectional DQ bus; replaces the ad-hoc wr_en/rd_en arbitration currently done in the benches.

Parameters:
- DATA_W, 16, SDRAM DQ width.
- ADDR_W, 13, SDRAM address width.

Ports:
- sys_clk  in  1  100 MHz controller clock
- sys_rst_n  in  1  async active-low reset
- init_cmd  in  4  {cs_n,ras_n,cas_n,we_n} from init
- init_ba  in  2  bank from init
- init_addr  in  ADDR_W  address from init
- init_end  in  1  init complete, level, stays high
- aref_req  in  1  refresh request, held until granted
- aref_end  in  1  one-cycle pulse, refresh done
- aref_cmd / aref_ba / aref_addr  in  4 / 2 / ADDR_W  refresh command bus
- wr_req  in  1  write burst request, held until granted
- wr_end  in  1  one-cycle pulse, write done
- wr_cmd / wr_ba / wr_addr  in  4 / 2 / ADDR_W  write command bus
- wr_sdram_en  in  1  write module wants DQ driven
- wr_data  in  DATA_W  write data
- rd_req  in  1  read burst request, held until granted
- rd_end  in  1  one-cycle pulse, read done
- rd_cmd / rd_ba / rd_addr  in  4 / 2 / ADDR_W  read command bus
- aref_en  out  1  refresh grant
- wr_en  out  1  write grant
- rd_en  out  1  read grant
- sdram_rd_data  out  DATA_W  DQ sampled value, forwarded to read module
- sdram_cke  out  1  clock enable
- sdram_cs_n / sdram_ras_n / sdram_cas_n / sdram_we_n  out  1 each  command pins
- sdram_ba  out  2  bank pins
- sdram_addr  out  ADDR_W  address pins
- sdram_dq  inout  DATA_W  data pins

Behaviour:
- States: IDLE, ARBIT, AREF, WRITE, READ. Reset state is IDLE.
- Reset values: aref_en = wr_en = rd_en = 0; sdram_cke = 1; DQ at high-Z.
- IDLE:
  - Pins follow init_cmd/init_ba/init_addr combinationally.
  - Go to ARBIT on the cycle init_end = 1.
- ARBIT:
  - Pins carry NOP (cmd 4'b0111), ba = 2'b11, addr = all-ones.
  - Priority, evaluated each cycle: aref_req, then wr_req, then rd_req. Next state is AREF, WRITE or READ accordingly.
  - With no request, stay in ARBIT.
- Grant outputs are decoded directly from the registered state: aref_en = (state==AREF), and likewise for wr_en and rd_en.
  - The grant therefore rises one cycle after the request is seen in ARBIT.
  - Exactly one grant is high at any time.
- AREF / WRITE / READ:
  - Pins follow the granted requester's cmd/ba/addr combinationally.
  - On the matching *_end pulse, next state is ARBIT and the grant drops the following cycle.
  - *_end from a non-granted module is ignored.
- No preemption. A refresh request arriving mid-burst waits until the burst's *_end; the write/read modules are responsible for terminating bursts early when aref_req is pending.
- Simultaneous *_end and new requests: the state returns to ARBIT first, so there is at least one NOP cycle between grants.
- DQ drive:
  - sdram_dq = wr_data when state==WRITE and wr_sdram_en = 1; otherwise high-Z.
  - sdram_rd_data = sdram_dq continuously.
- init_end low outside IDLE is not a supported case; no recovery is required.
- Reset mid-operation: asynchronous return to IDLE, all grants 0, DQ released the same instant.

Optional Feature:
- Macro: SDRAM_ARBIT_RR_EN.
- Defined:
  - A 1-bit last_grant register (reset 0 = write) tracks the most recent write/read grant.
  - When wr_req and rd_req are both pending in ARBIT with no aref_req, the side not granted last wins.
  - last_grant updates on entry to WRITE or READ.
  - Refresh keeps absolute priority.
- Undefined: fixed write-over-read priority; no last_grant register.

Decomposition:
- Shared package sdram_pkg holds:
  - command constants: NOP 4'b0111, PRECHARGE 4'b0010, AREF 4'b0001, MRS 4'b0000, ACTIVE 4'b0011, WRITE 4'b0100, READ 4'b0101;
  - the arbiter state encoding;
  - default DATA_W/ADDR_W.
- sdram_init, sdram_write and sdram_read adopt the same constants.
- No sub-module; the pin mux and FSM are a single block.

Test Plan:
- Reset, then init_end rises at t0 -> pins follow init_* before t0; NOP at t0+1; all grants stay 0 with no requests.
- aref_req held in ARBIT -> aref_en = 1 one cycle later; aref_end pulse -> aref_en = 0 next cycle and a NOP cycle appears on the pins.
- wr_req and rd_req asserted together -> wr_en granted first; after wr_end, rd_en granted. With SDRAM_ARBIT_RR_EN, a repeat of the same pair grants rd_en first.
- aref_req asserted during a WRITE burst -> wr_en stays 1 until wr_end; aref_en is then granted ahead of a pending rd_req.
- WRITE with wr_sdram_en = 1 and wr_data = 16'h00A5 -> sdram_dq = 16'h00A5; READ state -> sdram_dq = Z and sdram_rd_data tracks the model's DQ.
- sys_rst_n pulsed low mid-READ -> rd_en = 0 and DQ = Z immediately; state IDLE until init_end.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM controller constants: command encodings, arbiter state
// encoding and default bus widths.
package sdram_pkg;

    localparam int SDRAM_DATA_W = 16;
    localparam int SDRAM_ADDR_W = 13;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_AREF      = 4'b0001;
    localparam logic [3:0] CMD_MRS       = 4'b0000;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_READ      = 4'b0101;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARBIT = 3'd1;
    localparam logic [2:0] ST_AREF  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;

endpackage

// File: rtl/sdram_arbit_if.sv
// Requester-side bus of the SDRAM arbiter: init/refresh/write/read command
// buses, req/end handshakes, grants and the read-data return path.
interface sdram_arbit_if
    import sdram_pkg::*;
#(
    parameter int DATA_W = SDRAM_DATA_W,
    parameter int ADDR_W = SDRAM_ADDR_W
);
    logic [3:0]        init_cmd;
    logic [1:0]        init_ba;
    logic [ADDR_W-1:0] init_addr;
    logic              init_end;

    logic              aref_req;
    logic              aref_end;
    logic [3:0]        aref_cmd;
    logic [1:0]        aref_ba;
    logic [ADDR_W-1:0] aref_addr;

    logic              wr_req;
    logic              wr_end;
    logic [3:0]        wr_cmd;
    logic [1:0]        wr_ba;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_sdram_en;
    logic [DATA_W-1:0] wr_data;

    logic              rd_req;
    logic              rd_end;
    logic [3:0]        rd_cmd;
    logic [1:0]        rd_ba;
    logic [ADDR_W-1:0] rd_addr;

    logic              aref_en;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] sdram_rd_data;

    modport master (
        output init_cmd, init_ba, init_addr, init_end,
        output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        output wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_data,
        output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        input  aref_en, wr_en, rd_en, sdram_rd_data
    );

    modport slave (
        input  init_cmd, init_ba, init_addr, init_end,
        input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_data,
        input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        output aref_en, wr_en, rd_en, sdram_rd_data
    );

endinterface

// File: rtl/sdram_arbit.sv
// SDRAM arbiter: grants refresh/write/read one at a time and muxes the owner's
// command onto the pins. Define SDRAM_ARBIT_RR_EN for write/read round-robin.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int DATA_W = SDRAM_DATA_W,
    parameter int ADDR_W = SDRAM_ADDR_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    sdram_arbit_if.slave      arb,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [1:0]        sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    inout  wire  [DATA_W-1:0] sdram_dq
);

    logic [2:0]        state, state_nxt;
    logic              wr_pick;
    logic [3:0]        cmd;
    logic [1:0]        ba;
    logic [ADDR_W-1:0] addr;

`ifdef SDRAM_ARBIT_RR_EN
    logic last_grant;  // 0 = write granted last, 1 = read

    // On a write/read tie the side not served last wins.
    assign wr_pick = arb.wr_req & ~(arb.rd_req & ~last_grant);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            last_grant <= 1'b0;
        else if (state == ST_ARBIT && state_nxt == ST_WRITE)
            last_grant <= 1'b0;
        else if (state == ST_ARBIT && state_nxt == ST_READ)
            last_grant <= 1'b1;
    end
`else
    assign wr_pick = arb.wr_req;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (arb.init_end) state_nxt = ST_ARBIT;
            ST_ARBIT: begin
                if (arb.aref_req)    state_nxt = ST_AREF;
                else if (wr_pick)    state_nxt = ST_WRITE;
                else if (arb.rd_req) state_nxt = ST_READ;
            end
            // Every grant returns through ARBIT, guaranteeing a NOP between owners.
            ST_AREF:  if (arb.aref_end) state_nxt = ST_ARBIT;
            ST_WRITE: if (arb.wr_end)   state_nxt = ST_ARBIT;
            ST_READ:  if (arb.rd_end)   state_nxt = ST_ARBIT;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    assign arb.aref_en = (state == ST_AREF);
    assign arb.wr_en   = (state == ST_WRITE);
    assign arb.rd_en   = (state == ST_READ);

    always_comb begin
        cmd  = CMD_NOP;
        ba   = 2'b11;
        addr = '1;
        case (state)
            ST_IDLE: begin
                cmd  = arb.init_cmd;
                ba   = arb.init_ba;
                addr = arb.init_addr;
            end
            ST_AREF: begin
                cmd  = arb.aref_cmd;
                ba   = arb.aref_ba;
                addr = arb.aref_addr;
            end
            ST_WRITE: begin
                cmd  = arb.wr_cmd;
                ba   = arb.wr_ba;
                addr = arb.wr_addr;
            end
            ST_READ: begin
                cmd  = arb.rd_cmd;
                ba   = arb.rd_ba;
                addr = arb.rd_addr;
            end
            default: ;
        endcase
    end

    assign sdram_cke = 1'b1;
    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
    assign sdram_ba   = ba;
    assign sdram_addr = addr;

    // DQ is driven only while the write module owns the bus and asks for it.
    assign sdram_dq = (state == ST_WRITE && arb.wr_sdram_en) ? arb.wr_data : 'z;
    assign arb.sdram_rd_data = sdram_dq;

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: directed scenarios then random requester traffic,
// compared each cycle against an ownership model of the arbitration rules.
module tb_sdram_arbit;
    import sdram_pkg::*;

    localparam int DW = 16;
    localparam int AW = 13;
    localparam int O_IDLE = 0, O_ARB = 1, O_AREF = 2, O_WR = 3, O_RD = 4;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic          sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]    sdram_ba;
    logic [AW-1:0] sdram_addr;
    wire  [DW-1:0] sdram_dq;
    logic [DW-1:0] tb_probe;

    int m_own  = O_IDLE;
    bit m_last = 1'b0;
    int n_chk  = 0;
    int n_err  = 0;

    sdram_arbit_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    sdram_arbit #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .arb        (bus),
        .sdram_cke  (sdram_cke),
        .sdram_cs_n (sdram_cs_n),
        .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n),
        .sdram_we_n (sdram_we_n),
        .sdram_ba   (sdram_ba),
        .sdram_addr (sdram_addr),
        .sdram_dq   (sdram_dq)
    );

    always #5 sys_clk = ~sys_clk;

    // The device model drives a probe pattern whenever the arbiter must float DQ.
    wire tb_dq_oe = !(m_own == O_WR && bus.wr_sdram_en);
    assign sdram_dq = tb_dq_oe ? tb_probe : 'z;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic m_update();
        bit rd_first;
        if (!sys_rst_n) begin
            m_own  = O_IDLE;
            m_last = 1'b0;
            return;
        end
        case (m_own)
            O_IDLE: if (bus.init_end) m_own = O_ARB;
            O_ARB: begin
                if (bus.aref_req) m_own = O_AREF;
                else if (bus.wr_req || bus.rd_req) begin
`ifdef SDRAM_ARBIT_RR_EN
                    rd_first = (m_last == 1'b0);
`else
                    rd_first = 1'b0;
`endif
                    if (bus.rd_req && (!bus.wr_req || rd_first)) begin
                        m_own = O_RD; m_last = 1'b1;
                    end else begin
                        m_own = O_WR; m_last = 1'b0;
                    end
                end
            end
            O_AREF: if (bus.aref_end) m_own = O_ARB;
            O_WR:   if (bus.wr_end)   m_own = O_ARB;
            O_RD:   if (bus.rd_end)   m_own = O_ARB;
            default: m_own = O_IDLE;
        endcase
    endtask

    task automatic check_all();
        logic [18:0]   pins;
        logic [DW-1:0] dq;
        case (m_own)
            O_IDLE:  pins = {bus.init_cmd, bus.init_ba, bus.init_addr};
            O_AREF:  pins = {bus.aref_cmd, bus.aref_ba, bus.aref_addr};
            O_WR:    pins = {bus.wr_cmd, bus.wr_ba, bus.wr_addr};
            O_RD:    pins = {bus.rd_cmd, bus.rd_ba, bus.rd_addr};
            default: pins = {4'b0111, 2'b11, 13'h1fff};
        endcase
        dq = tb_dq_oe ? tb_probe : bus.wr_data;
        chk("pins", 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr}), 32'(pins));
        chk("grants", 32'({bus.aref_en, bus.wr_en, bus.rd_en}),
            32'({m_own == O_AREF, m_own == O_WR, m_own == O_RD}));
        chk("cke", 32'(sdram_cke), 32'd1);
        chk("dq", 32'(sdram_dq), 32'(dq));
        chk("rd_data", 32'(bus.sdram_rd_data), 32'(dq));
    endtask

    task automatic settle_chk();
        #2;
        check_all();
    endtask

    task automatic clk();
        @(posedge sys_clk);
        m_update();
        #1;
    endtask

    task automatic step();
        settle_chk();
        clk();
    endtask

    task automatic rand_bus();
        bus.init_cmd  = 4'($urandom);  bus.init_ba = 2'($urandom);  bus.init_addr = 13'($urandom);
        bus.aref_cmd  = 4'($urandom);  bus.aref_ba = 2'($urandom);  bus.aref_addr = 13'($urandom);
        bus.wr_cmd    = 4'($urandom);  bus.wr_ba   = 2'($urandom);  bus.wr_addr   = 13'($urandom);
        bus.rd_cmd    = 4'($urandom);  bus.rd_ba   = 2'($urandom);  bus.rd_addr   = 13'($urandom);
        tb_probe      = 16'($urandom);
    endtask

    // Run the current write/read grant for len cycles, then pulse its end.
    task automatic burst(input int len);
        if (m_own == O_WR) bus.wr_req = 1'b0;
        if (m_own == O_RD) bus.rd_req = 1'b0;
        bus.wr_sdram_en = 1'b1;
        bus.wr_data     = 16'h00A5;
        repeat (len) begin
            rand_bus();
            settle_chk();
            if (m_own == O_WR) chk("dq_00a5", 32'(sdram_dq), 32'h00A5);
            clk();
        end
        if (m_own == O_WR) bus.wr_end = 1'b1;
        if (m_own == O_RD) bus.rd_end = 1'b1;
        step();
        bus.wr_end = 1'b0;
        bus.rd_end = 1'b0;
    endtask

    initial begin
        logic rq[3];
        int   rem[3];

        sys_rst_n = 1'b1;
        bus.init_end = 0; bus.aref_req = 0; bus.aref_end = 0;
        bus.wr_req = 0; bus.wr_end = 0; bus.wr_sdram_en = 0; bus.wr_data = '0;
        bus.rd_req = 0; bus.rd_end = 0;
        rand_bus();
        #1 sys_rst_n = 1'b0;
        step(); step();
        sys_rst_n = 1'b1;

        // Pins follow init until init_end, then NOP with no grants.
        repeat (3) begin rand_bus(); step(); end
        bus.init_end = 1'b1;
        rand_bus(); step();
        repeat (3) begin rand_bus(); step(); end

        // Refresh handshake with a NOP cycle afterwards.
        bus.aref_req = 1'b1; step();
        bus.aref_req = 1'b0; step(); rand_bus(); step();
        bus.aref_end = 1'b1; step();
        bus.aref_end = 1'b0; step();

        // Simultaneous write and read requests, twice.
        repeat (2) begin
            bus.wr_req = 1'b1; bus.rd_req = 1'b1; step();
            burst(2);
            step();
            burst(2);
            step();
        end

        // Refresh arriving mid-write waits for wr_end, then beats a pending read.
        bus.wr_req = 1'b1; step();
        bus.wr_req = 1'b0; bus.wr_sdram_en = 1'b1; bus.wr_data = 16'h00A5; step();
        bus.aref_req = 1'b1; bus.rd_req = 1'b1; step(); step();
        bus.wr_end = 1'b1; step();
        bus.wr_end = 1'b0; step();
        bus.aref_req = 1'b0; step();
        bus.aref_end = 1'b1; step();
        bus.aref_end = 1'b0; step();
        bus.rd_req = 1'b0; rand_bus(); step(); rand_bus(); step();

        // Asynchronous reset while reading.
        rand_bus();
        sys_rst_n = 1'b0; bus.init_end = 1'b0;
        m_own = O_IDLE; m_last = 1'b0;
        settle_chk();
        chk("rst_rd_en", 32'(bus.rd_en), 32'd0);
        clk();
        sys_rst_n = 1'b1;
        repeat (2) begin rand_bus(); step(); end
        bus.init_end = 1'b1; step(); step();

        // Random protocol-respecting traffic.
        for (int i = 0; i < 3; i++) begin rq[i] = 1'b0; rem[i] = 0; end
        for (int c = 0; c < 800; c++) begin
            logic ed[3];
            for (int i = 0; i < 3; i++) begin
                ed[i] = 1'b0;
                if (m_own == O_AREF + i) begin
                    rq[i] = 1'b0;
                    if (rem[i] == 0) ed[i] = 1'b1;
                    else rem[i]--;
                end else begin
                    if (!rq[i] && $urandom_range(0, 5) == 0) begin
                        rq[i]  = 1'b1;
                        rem[i] = $urandom_range(0, 4);
                    end
                    if ($urandom_range(0, 11) == 0) ed[i] = 1'b1;
                end
            end
            bus.aref_req = rq[0]; bus.wr_req = rq[1]; bus.rd_req = rq[2];
            bus.aref_end = ed[0]; bus.wr_end = ed[1]; bus.rd_end = ed[2];
            bus.wr_sdram_en = 1'($urandom);
            bus.wr_data     = 16'($urandom);
            rand_bus();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
